// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - serializes an 8-bit word onto a 1-to-8 demux, one channel per dwell period
module demux_sel_sequencer #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       abort,
  output logic       a,
  output logic [2:0] sel,
  output logic       a_valid,
  output logic       busy,
  output logic       done
);

  if (DWELL < 1 || DWELL > 255) begin : g_dwell_check
    $error("demux_sel_sequencer: DWELL must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] sel_q, sel_d;
  logic       a_q, a_d;
  logic       a_valid_q, a_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       in_ready_q, in_ready_d;
  logic       accept;

  // A new word can be taken from IDLE or from the single DONE cycle; abort always wins.
  assign accept = (state_q != DRIVE) && in_valid && !abort;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    a_d        = 1'b0;
    a_valid_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    in_ready_d = 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = DRIVE;
          word_d     = in_data;
          dwell_d    = 8'd0;
          sel_d      = 3'd0;
          a_d        = in_data[0];
          a_valid_d  = 1'b1;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end else begin
          state_d = IDLE;
          dwell_d = 8'd0;
          sel_d   = 3'd0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          word_d  = 8'd0;
          dwell_d = 8'd0;
          sel_d   = 3'd0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          if (sel_q != 3'd7) begin
            sel_d      = sel_q + 3'd1;
            a_d        = word_q[sel_q + 3'd1];
            a_valid_d  = 1'b1;
            busy_d     = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          // Mid-dwell: hold the current bit and channel.
          dwell_d    = dwell_q + 8'd1;
          a_d        = a_q;
          a_valid_d  = 1'b1;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
        dwell_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= 8'd0;
      dwell_q    <= 8'd0;
      sel_q      <= 3'd0;
      a_q        <= 1'b0;
      a_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      dwell_q    <= dwell_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      a_valid_q  <= a_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign a        = a_q;
  assign sel      = sel_q;
  assign a_valid  = a_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb/tb_demux_sel_sequencer.sv - randomized and directed bench for demux_sel_sequencer (DWELL=1 and DWELL=3)
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       abort = 1'b0;

  logic       in_ready1, a1, a_valid1, busy1, done1;
  logic [2:0] sel1;
  logic       in_ready3, a3, a_valid3, busy3, done3;
  logic [2:0] sel3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_sel_sequencer #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .abort(abort), .a(a1), .sel(sel1),
    .a_valid(a_valid1), .busy(busy1), .done(done1)
  );

  demux_sel_sequencer #(.DWELL(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .abort(abort), .a(a3), .sel(sel3),
    .a_valid(a_valid3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Frame model: cycle index k counted from the accept edge (k=0 is the first bit).
  // Bits occupy k=0..8*D-1, bit k/D on channel k/D; done is the single cycle k=8*D.
  int   dw[2] = '{1, 3};
  int   cyc = 0;
  bit   inframe[2] = '{0, 0};
  int   mstart[2] = '{0, 0};
  logic [7:0] mw[2];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int  k;
      bit  drive, capable;
      k       = cyc - mstart[j];
      drive   = inframe[j] && (k < 8 * dw[j]);
      capable = !inframe[j] || (k == 8 * dw[j]);
      if (!rst_n) inframe[j] = 0;
      else if (drive && abort) inframe[j] = 0;
      else if (capable && in_valid && !abort) begin
        inframe[j] = 1;
        mstart[j]  = cyc + 1;
        mw[j]      = in_data;
      end else if (inframe[j] && k == 8 * dw[j]) inframe[j] = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int k;
      int e_sel, e_a, e_av, e_busy, e_done, e_rdy;
      e_sel = 0; e_a = 0; e_av = 0; e_busy = 0; e_done = 0; e_rdy = 1;
      if (rst_n && inframe[j]) begin
        k = cyc - mstart[j];
        if (k < 8 * dw[j]) begin
          e_sel = k / dw[j]; e_a = int'(mw[j][e_sel]); e_av = 1; e_busy = 1; e_rdy = 0;
        end else begin
          e_sel = 7; e_done = 1;
        end
      end
      if (j == 0) begin
        chk("d1_sel", int'(sel1), e_sel);   chk("d1_a", int'(a1), e_a);
        chk("d1_a_valid", int'(a_valid1), e_av); chk("d1_busy", int'(busy1), e_busy);
        chk("d1_done", int'(done1), e_done); chk("d1_in_ready", int'(in_ready1), e_rdy);
      end else begin
        chk("d3_sel", int'(sel3), e_sel);   chk("d3_a", int'(a3), e_a);
        chk("d3_a_valid", int'(a_valid3), e_av); chk("d3_busy", int'(busy3), e_busy);
        chk("d3_done", int'(done3), e_done); chk("d3_in_ready", int'(in_ready3), e_rdy);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one word at a negedge; returns at the negedge of cycle k=0.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] a5_bits;
    a5_bits = 8'hA5;

    idle(3);
    rst_n = 1'b1;
    idle(5);
    chk("lit_idle_ready", int'(in_ready1), 1);
    chk("lit_idle_sel", int'(sel1), 0);

    // 0xA5 at DWELL=1: a = 1,0,1,0,0,1,0,1 on sel 0..7, then done
    send(8'hA5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("lit_a5_sel", int'(sel1), i);
      chk("lit_a5_a", int'(a1), int'(a5_bits[i]));
    end
    @(negedge clk);
    chk("lit_a5_done", int'(done1), 1);
    chk("lit_a5_ready", int'(in_ready1), 1);
    idle(30);

    // 0x01 at DWELL=3: bit 0 held three cycles, done at k=24
    send(8'h01);
    chk("lit_01_k0_a", int'(a3), 1);
    idle(2);
    chk("lit_01_k2_sel", int'(sel3), 0);
    idle(1);
    chk("lit_01_k3_sel", int'(sel3), 1);
    chk("lit_01_k3_a", int'(a3), 0);
    idle(21);
    chk("lit_01_done", int'(done3), 1);
    idle(5);

    // Back-to-back with in_valid held high; data change during DRIVE ignored
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_data = 8'h00;
    idle(8);
    chk("lit_b2b_done", int'(done1), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lit_b2b_av", int'(a_valid1), 1);
    chk("lit_b2b_a", int'(a1), 0);
    idle(40);

    // Abort at sel=4
    send(8'hF0);
    idle(4);
    chk("lit_abort_sel4", int'(sel1), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("lit_abort_av", int'(a_valid1), 0);
    chk("lit_abort_ready", int'(in_ready1), 1);
    idle(12);

    // Asynchronous reset mid-frame at sel=5
    send(8'hFF);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_av", int'(a_valid1), 0);
    chk("lit_rst_sel", int'(sel1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send(8'h80);
    idle(6);
    chk("lit_80_k6_a", int'(a1), 0);
    @(negedge clk);
    chk("lit_80_k7_a", int'(a1), 1);
    idle(30);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 99) < 40);
      in_data  = 8'($urandom);
      abort    = ($urandom_range(0, 99) < 4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
